// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: sequencer state encoding,
// opcode constants and the halt magic value checked in WB.
package pipe_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        STALL  = 3'd1,
        DRAIN  = 3'd2,
        HALTED = 3'd3
    } state_t;

    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_JALR    = 7'b1100111;
    localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;
    localparam logic [31:0] HALT_MAGIC = 32'hc;

    // Wide enough for a load latency of up to 7 stall cycles.
    localparam int STALL_CNT_W = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters; it
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out <= '0;
        end else if (inc && (out != {WIDTH{1'b1}})) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use stalls, EX redirect flushes, ECALL
// drain and halt freeze, plus stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_halt_cand,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             wb_halt_cand,
    input  logic             wb_halt_ok,
    output logic             pc_hold,
    output logic             pc_redirect,
    output logic             ifid_latchn,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t                 state;
    logic [STALL_CNT_W-1:0] stallLeft;
    logic                   drainFirst;
    logic                   hz;
    logic                   stallInc;
    logic                   flushInc;

    assign hz = ex_is_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_hold     = 1'b0;
        pc_redirect = 1'b0;
        ifid_latchn = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        stallInc    = 1'b0;
        flushInc    = 1'b0;
        if (RSTn) begin
            unique case (state)
                RUN: begin
                    // A redirect wins: whatever sits in ID is on the wrong path.
                    if (ex_redirect) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        flushInc    = 1'b1;
                    end else if (hz) begin
                        pc_hold     = 1'b1;
                        ifid_latchn = 1'b1;
                        idex_flush  = 1'b1;
                        stallInc    = 1'b1;
                    end else if (id_halt_cand) begin
                        pc_hold     = 1'b1;
                        ifid_flush  = 1'b1;
                    end
                end
                STALL: begin
                    pc_hold     = 1'b1;
                    ifid_latchn = 1'b1;
                    idex_flush  = 1'b1;
                    stallInc    = 1'b1;
                end
                DRAIN: begin
                    // The ECALL itself moves into EX on the first drain cycle.
                    pc_hold     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = !drainFirst;
                end
                HALTED: begin
                    pc_hold     = 1'b1;
                    ifid_latchn = 1'b1;
                    idex_flush  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= RUN;
            stallLeft  <= '0;
            drainFirst <= 1'b0;
            halt       <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!ex_redirect) begin
                        if (hz) begin
                            if (LOAD_LAT > 1) begin
                                stallLeft <= STALL_CNT_W'(LOAD_LAT - 1);
                                state     <= STALL;
                            end
                        end else if (id_halt_cand) begin
                            drainFirst <= 1'b1;
                            state      <= DRAIN;
                        end
                    end
                end
                STALL: begin
                    stallLeft <= stallLeft - 1'b1;
                    if (stallLeft == STALL_CNT_W'(1)) begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    drainFirst <= 1'b0;
                    if (wb_halt_cand) begin
                        if (wb_halt_ok) begin
                            halt  <= 1'b1;
                            state <= HALTED;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

    assign state_o = state;

    sat_counter #(.WIDTH(CNT_W)) uStallCnt (
        .CLK  (CLK),
        .RSTn (RSTn),
        .inc  (stallInc),
        .out  (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) uFlushCnt (
        .CLK  (CLK),
        .RSTn (RSTn),
        .inc  (flushInc),
        .out  (flush_cnt)
    );

endmodule
